// File: rtl/rx_pkg.sv
// Shared defaults and helpers for the rx_buf receive buffer.
package rx_pkg;

  localparam int RX_DATA_W = 32;
  localparam int RX_DEPTH  = 4;
  localparam int RX_CNT_W  = 16;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// Word storage for rx_buf: one synchronous write port, one asynchronous read port.
module rx_buf_mem import rx_pkg::*; #(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy tracking makes them don't-care.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_buf.sv
// Valid/ready FIFO receive buffer with last-word display and accepted-word counter.
module rx_buf import rx_pkg::*; #(
  parameter int DATA_W = RX_DATA_W,
  parameter int DEPTH  = RX_DEPTH,
  parameter int CNT_W  = RX_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       data_show,
  output logic [clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]        acc_cnt
);

  localparam int         AW       = clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          push;
  logic          pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (level != '0);

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  // in_ready is registered from the next occupancy, so it stays low during reset
  // and first rises on the edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      data_show <= '0;
      acc_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        data_show <= in_data;
        acc_cnt   <= acc_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level    <= level_next;
      in_ready <= (level_next != LVL_FULL);
    end
  end

  rx_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_rx_buf.sv
// Self-checking bench for rx_buf: directed steps plus random traffic against a queue model.
module tb_rx_buf;
  import rx_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LW     = clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data_show;
  logic [LW-1:0]     level;
  logic [15:0]       acc_cnt;

  logic [DATA_W-1:0] c_in_data = '0;
  logic              c_in_valid = 1'b0;
  logic              c_in_ready;
  logic [DATA_W-1:0] c_out_data;
  logic              c_out_valid;
  logic              c_out_ready = 1'b1;
  logic [DATA_W-1:0] c_data_show;
  logic [LW-1:0]     c_level;
  logic [3:0]        c_acc_cnt;

  rx_buf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .data_show(data_show), .level(level), .acc_cnt(acc_cnt)
  );

  rx_buf #(.DATA_W(32), .DEPTH(4), .CNT_W(4)) dut_cnt4 (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .data_show(c_data_show), .level(c_level), .acc_cnt(c_acc_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] q [$];
  logic              exp_ready = 1'b0;
  logic [DATA_W-1:0] exp_show = '0;
  int unsigned       exp_acc = 0;
  int                n_assert = 0;
  int                n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
    check("level", 64'(level), 64'(q.size()));
    check("data_show", 64'(data_show), 64'(exp_show));
    check("acc_cnt", 64'(acc_cnt), 64'(exp_acc % 65536));
  endtask

  // One clock of traffic: check state, drive inputs, then advance the model at the edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, output logic accepted);
    logic do_pop;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    accepted  = v && exp_ready;
    do_pop    = r && (q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (accepted) begin
      q.push_back(d);
      exp_show = d;
      exp_acc++;
    end
    exp_ready = (q.size() != DEPTH);
  endtask

  task automatic quiesce();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_acc_cnt", 64'(acc_cnt), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    q.delete();
    exp_show  = '0;
    exp_acc   = 0;
    exp_ready = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("release_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    exp_ready = 1'b1;
  endtask

  initial begin
    logic              acc;
    logic              have;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] last;

    repeat (2) @(negedge clk);
    check("init_level", 64'(level), 64'(0));
    check("init_out_valid", 64'(out_valid), 64'(0));
    check("init_in_ready", 64'(in_ready), 64'(0));
    check("init_data_show", 64'(data_show), 64'(0));
    check("init_acc_cnt", 64'(acc_cnt), 64'(0));
    check("init_c_acc_cnt", 64'(c_acc_cnt), 64'(0));
    rst = 1'b0;
    #1 check("release_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    exp_ready = 1'b1;

    // Single word after reset.
    step(1'b1, 32'hA5A5_0001, 1'b0, acc);
    quiesce();
    check("single_out_valid", 64'(out_valid), 64'(1));
    check("single_out_data", 64'(out_data), 64'hA5A5_0001);
    check("single_data_show", 64'(data_show), 64'hA5A5_0001);
    check("single_level", 64'(level), 64'(1));
    check("single_acc_cnt", 64'(acc_cnt), 64'(1));
    step(1'b0, '0, 1'b1, acc);

    // Fill to full, hold a fifth word, then drain.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, acc);
    step(1'b1, 32'd5, 1'b0, acc);
    quiesce();
    check("full_level", 64'(level), 64'(4));
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_head", 64'(out_data), 64'(1));
    step(1'b1, 32'd5, 1'b1, acc);
    check("full_pop_no_push", 64'(acc), 64'(0));
    step(1'b1, 32'd5, 1'b1, acc);
    check("after_pop_push", 64'(acc), 64'(1));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, acc);
    quiesce();
    check("drained_out_valid", 64'(out_valid), 64'(0));
    check("drained_acc_cnt", 64'(acc_cnt), 64'(6));

    // Streaming 0..19 with both sides always willing.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 32'(i), 1'b1, acc);
    quiesce();
    check("stream_acc_cnt", 64'(acc_cnt), 64'(20));
    check("stream_level", 64'(level), 64'(1));
    check("stream_last", 64'(out_data), 64'(19));
    step(1'b0, '0, 1'b1, acc);

    // Random stalls on both sides; a held word stays stable until accepted.
    have = 1'b0;
    word = '0;
    for (int i = 0; i < 80; i++) begin
      if (!have) begin
        word = $urandom;
        have = ($urandom_range(0, 3) != 0);
      end
      step(have, word, ($urandom_range(0, 2) == 0), acc);
      if (acc) have = 1'b0;
      check("level_bound", 64'(level <= LW'(DEPTH)), 64'(1));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, acc);

    // Reset with three words buffered.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, acc);
    do_reset();
    step(1'b1, 32'h0000_00FF, 1'b0, acc);
    quiesce();
    check("post_reset_first", 64'(out_data), 64'h0000_00FF);
    check("post_reset_level", 64'(level), 64'(1));

    // Counter wrap on the 4-bit counter instance.
    last = '0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      c_in_valid = 1'b1;
      c_in_data  = $urandom;
      last       = c_in_data;
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    check("cnt4_acc_cnt", 64'(c_acc_cnt), 64'(17 % 16));
    check("cnt4_data_show", 64'(c_data_show), 64'(last));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_buf.md
RX_BUF -- requirements
Module: rx_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the buffer depth in words; legal values are powers of two, 2 to 256.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-word counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: the upstream data word.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data holds a word offered for transfer.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: the oldest buffered word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream takes out_data this cycle.
REQ-012 The block SHALL have port data_show, output, DATA_W bits: the most recently accepted word.
REQ-013 The block SHALL have port level, output, clog2(DEPTH)+1 bits: the current occupancy.
REQ-014 The block SHALL have port acc_cnt, output, CNT_W bits: the total number of words accepted.

Function
REQ-015 A push SHALL occur on a rising edge where in_valid and in_ready are both 1, and a pop SHALL occur on a rising edge where out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (level != DEPTH), be derived from registered state only, and have no combinational path from in_valid or out_ready.
REQ-017 out_valid SHALL equal (level != 0), and out_data SHALL be the head entry, driven from registered state with no bypass from in_data.
REQ-018 Latency SHALL be one cycle: a word pushed into an empty buffer at edge N makes out_valid 1 after edge N and stay 1 until popped.
REQ-019 Ordering SHALL be strictly FIFO, with no word dropped, duplicated or reordered.
REQ-020 A simultaneous push and pop SHALL leave level unchanged and SHALL be legal at any level from 1 to DEPTH-1.
REQ-021 When full (level = DEPTH), in_ready SHALL be 0 and no push SHALL occur, even with a same-cycle pop; in_ready SHALL become 1 the cycle after a pop.
REQ-022 When empty, out_valid SHALL be 0, out_ready SHALL be ignored, and out_data is don't-care.
REQ-023 The read and write pointers SHALL be clog2(DEPTH) bits wide, increment modulo DEPTH, and wrap from DEPTH-1 to 0 with no other effect.
REQ-024 level SHALL be +1 on push only, -1 on pop only, and unchanged otherwise.
REQ-025 data_show SHALL load in_data on every push and hold its value otherwise.
REQ-026 acc_cnt SHALL increment by 1 on every push and wrap modulo 2^CNT_W.
REQ-027 Upstream SHALL hold in_data and in_valid stable while in_valid=1 and in_ready=0; the block SHALL not depend on in_valid being deasserted between words.

Reset
REQ-028 While rst=1, the block SHALL hold level=0, both pointers=0, out_valid=0, in_ready=0, data_show=0 and acc_cnt=0.
REQ-029 in_ready SHALL rise on the first rising clk edge after rst deasserts.
REQ-030 Assertion of rst mid-transfer SHALL discard all buffered words immediately, and no partial push or pop SHALL complete.
REQ-031 Storage array contents SHALL not be reset.

Structure
REQ-032 Package rx_pkg SHALL hold the default constants RX_DATA_W=32, RX_DEPTH=4 and RX_CNT_W=16, plus a clog2 helper function.
REQ-033 Storage SHALL be in one sub-module, rx_buf_mem: DEPTH x DATA_W registers with one write port and one asynchronous read port, and no reset.
REQ-034 Pointers, level, counters and handshake logic SHALL reside in rx_buf.

Verification
REQ-035 Reset then single word: push 32'hA5A5_0001 with out_ready=0 -> out_valid=1 one cycle later, out_data=32'hA5A5_0001, data_show=32'hA5A5_0001, level=1, acc_cnt=1.
REQ-036 Fill to full with DEPTH=4 and out_ready=0: push 1,2,3,4 then hold 5 -> in_ready=0 at level=4; set out_ready=1 -> pops in order 1,2,3,4, and 5 is accepted the cycle after the first pop.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 20 cycles with data 0..19 -> level stays 1 after the first word, output sequence is 0..19, acc_cnt=20.
REQ-038 Wrap-around: 10 push/pop pairs at DEPTH=4 with random stalls on both sides -> output order matches input, pointers wrap, level never exceeds 4.
REQ-039 Reset mid-operation: rst asserted at level=3 -> out_valid=0, level=0 and acc_cnt=0 within the same cycle; after release a new word 32'h0000_00FF emerges first.
REQ-040 Counter wrap with CNT_W=4: 17 pushes -> acc_cnt=1, and data_show equals the 17th word.
